// File: rtl/rrf_recovery_ctrl_if.sv
// Handshake bundle between the RRF recovery controller and ROB/RRF/RAT/free-list.
// master = recovery controller, slave = surrounding pipeline.
interface rrf_recovery_ctrl_if #(
    parameter int unsigned NUM_REGS   = 64,
    parameter int unsigned ARCH_REGS  = 32,
    parameter int unsigned COPY_LANES = 4
);
    localparam int unsigned PW = $clog2(NUM_REGS);
    localparam int unsigned AW = $clog2(ARCH_REGS);

    logic                                flush_req;
    logic [ARCH_REGS-1:0][PW-1:0]        rrf_map;
    logic                                commit_stall;
    logic                                busy;
    logic [COPY_LANES-1:0]               rat_we;
    logic [COPY_LANES-1:0][AW-1:0]       rat_idx;
    logic [COPY_LANES-1:0][PW-1:0]       rat_preg;
    logic                                fl_clear;
    logic                                fl_push;
    logic [PW-1:0]                       fl_push_reg;
    logic                                fl_push_ready;
    logic                                recovery_done;

    modport master (
        input  flush_req, rrf_map, fl_push_ready,
        output commit_stall, busy, rat_we, rat_idx, rat_preg,
               fl_clear, fl_push, fl_push_reg, recovery_done
    );

    modport slave (
        output flush_req, rrf_map, fl_push_ready,
        input  commit_stall, busy, rat_we, rat_idx, rat_preg,
               fl_clear, fl_push, fl_push_reg, recovery_done
    );
endinterface

// File: rtl/rrf_recovery_ctrl.sv
// Front-end recovery after a flush: freezes commit, copies the RRF into the RAT,
// then rebuilds the free list from every physical register the RRF does not hold.
module rrf_recovery_ctrl #(
    parameter int unsigned NUM_REGS   = 64,
    parameter int unsigned ARCH_REGS  = 32,
    parameter int unsigned COPY_LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rrf_recovery_ctrl_if.master  rec_if
);
    localparam int unsigned PW = $clog2(NUM_REGS);
    localparam int unsigned AW = $clog2(ARCH_REGS);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COPY,
        SCAN,
        DONE
    } state_e;

    state_e              state_q;
    logic [AW-1:0]       arch_ptr_q;
    logic [PW:0]         phys_ptr_q;
    logic                pending_q;
    logic [NUM_REGS-1:0] mapped_q;
    logic [NUM_REGS-1:0] mapped_d;

    logic in_copy;
    logic in_scan;
    logic last_grp;
    logic last_phys;
    logic scan_mapped;
    logic scan_adv;

    // Bitmap of physical registers currently held by the RRF; p0 is pinned by x0.
    always_comb begin
        mapped_d = '0;
        for (int unsigned a = 0; a < ARCH_REGS; a++) begin
            mapped_d[rec_if.rrf_map[a]] = 1'b1;
        end
        mapped_d[0] = 1'b1;
    end

    assign in_copy     = (state_q == COPY);
    assign in_scan     = (state_q == SCAN);
    assign last_grp    = (arch_ptr_q == AW'(ARCH_REGS - COPY_LANES));
    assign last_phys   = (phys_ptr_q == (PW + 1)'(NUM_REGS - 1));
    assign scan_mapped = mapped_q[phys_ptr_q[PW-1:0]];
    assign scan_adv    = scan_mapped | rec_if.fl_push_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            arch_ptr_q <= '0;
            phys_ptr_q <= '0;
            pending_q  <= 1'b0;
            mapped_q   <= '0;
        end else begin
            // Requests arriving mid-recovery collapse into a single rerun.
            if (rec_if.flush_req && (state_q != IDLE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rec_if.flush_req) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    mapped_q   <= mapped_d;
                    arch_ptr_q <= '0;
                    state_q    <= COPY;
                end
                COPY: begin
                    arch_ptr_q <= arch_ptr_q + AW'(COPY_LANES);
                    if (last_grp) begin
                        phys_ptr_q <= '0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_adv) begin
                        if (last_phys) begin
                            state_q <= DONE;
                        end else begin
                            phys_ptr_q <= phys_ptr_q + (PW + 1)'(1);
                        end
                    end
                end
                DONE: begin
                    pending_q <= 1'b0;
                    state_q   <= (pending_q || rec_if.flush_req) ? SETTLE : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Commit is blocked combinationally so a commit in the request cycle cannot slip through.
    assign rec_if.commit_stall  = rec_if.flush_req | (state_q != IDLE);
    assign rec_if.busy          = (state_q != IDLE);
    assign rec_if.fl_clear      = (state_q == SETTLE);
    assign rec_if.fl_push       = in_scan & ~scan_mapped;
    assign rec_if.fl_push_reg   = (in_scan & ~scan_mapped) ? phys_ptr_q[PW-1:0] : '0;
    assign rec_if.recovery_done = (state_q == DONE);

    // RRF is frozen while busy, so lanes read it live.
    for (genvar l = 0; l < COPY_LANES; l++) begin : g_lane
        logic [AW-1:0] lane_idx;
        assign lane_idx               = arch_ptr_q + AW'(l);
        assign rec_if.rat_we[l]       = in_copy;
        assign rec_if.rat_idx[l]      = in_copy ? lane_idx : '0;
        assign rec_if.rat_preg[l]     = in_copy ? rec_if.rrf_map[lane_idx] : '0;
    end
endmodule

// File: tb/tb_rrf_recovery_ctrl.sv
// Self-checking bench for rrf_recovery_ctrl: table of recovery scenarios checked through
// RAT-write and free-list-push scoreboards, plus hand-written rerun and reset sequences.
module tb_rrf_recovery_ctrl;
    localparam int unsigned NUM_REGS   = 64;
    localparam int unsigned ARCH_REGS  = 32;
    localparam int unsigned COPY_LANES = 4;
    localparam int unsigned PW         = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rrf_recovery_ctrl_if #(.NUM_REGS(NUM_REGS), .ARCH_REGS(ARCH_REGS), .COPY_LANES(COPY_LANES)) bus ();

    rrf_recovery_ctrl #(.NUM_REGS(NUM_REGS), .ARCH_REGS(ARCH_REGS), .COPY_LANES(COPY_LANES)) dut (
        .clk    (clk),
        .rst    (rst),
        .rec_if (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scenario: up to two remapped arch regs, optional ready stall on one pushed reg.
    typedef struct {
        int a0, p0, a1, p1;
        int stall_reg, stall_len;
        int exp_pushes;
        int exp_done_off;
    } case_t;

    case_t cases[4];

    // RAT writes encoded as idx*256+preg; pushes as the phys reg number.
    int exp_rat[$];
    int exp_push[$];

    logic mon_en = 1'b0;
    int   cyc = 0, settle_cyc = 0, done_cyc = 0;
    int   done_cnt = 0, push_cnt = 0, rat_cnt = 0, clear_cnt = 0;
    bit   prev_held = 1'b0;
    int   prev_reg = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.fl_clear) begin
                settle_cyc = cyc;
                clear_cnt++;
            end
            if (bus.recovery_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            for (int l = 0; l < COPY_LANES; l++) begin
                if (bus.rat_we[l]) begin
                    rat_cnt++;
                    if (exp_rat.size() == 0) chk("rat_unexpected_write", 1, 0);
                    else chk("rat_write", int'(bus.rat_idx[l]) * 256 + int'(bus.rat_preg[l]),
                             exp_rat.pop_front());
                end
            end
            if (prev_held) begin
                chk("push_hold_valid", 32'(bus.fl_push), 1);
                chk("push_hold_reg", 32'(bus.fl_push_reg), prev_reg);
            end
            if (bus.fl_push && bus.fl_push_ready) begin
                push_cnt++;
                if (exp_push.size() == 0) chk("push_unexpected", 1, 0);
                else chk("push_reg", 32'(bus.fl_push_reg), exp_push.pop_front());
            end
            prev_held = bus.fl_push && !bus.fl_push_ready;
            prev_reg  = int'(bus.fl_push_reg);
        end
    end

    task automatic build_exp(input case_t c);
        int map[ARCH_REGS];
        bit mapped[NUM_REGS];
        for (int a = 0; a < ARCH_REGS; a++) map[a] = a;
        if (c.a0 >= 0) map[c.a0] = c.p0;
        if (c.a1 >= 0) map[c.a1] = c.p1;
        for (int p = 0; p < NUM_REGS; p++) mapped[p] = 1'b0;
        mapped[0] = 1'b1;
        for (int a = 0; a < ARCH_REGS; a++) begin
            bus.rrf_map[a] = PW'(map[a]);
            exp_rat.push_back(a * 256 + map[a]);
            mapped[map[a]] = 1'b1;
        end
        for (int p = 0; p < NUM_REGS; p++) if (!mapped[p]) exp_push.push_back(p);
    endtask

    task automatic reset_stats();
        done_cnt = 0; push_cnt = 0; rat_cnt = 0; clear_cnt = 0;
        settle_cyc = 0; done_cyc = 0;
    endtask

    // One-cycle flush pulse from IDLE; commit must already be stalled in the request cycle.
    task automatic pulse_flush_from_idle();
        @(posedge clk); #1;
        bus.flush_req = 1'b1;
        #1;
        chk("stall_in_req_cycle", 32'(bus.commit_stall), 1);
        chk("idle_not_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        chk("settle_fl_clear", 32'(bus.fl_clear), 1);
        chk("settle_stall", 32'(bus.commit_stall), 1);
    endtask

    task automatic run_case(input case_t c);
        int  stall_left;
        bit  stall_done;
        bit  seen_done;
        reset_stats();
        @(posedge clk); #1;
        build_exp(c);
        pulse_flush_from_idle();
        stall_left = 0;
        stall_done = 1'b0;
        seen_done  = 1'b0;
        for (int i = 0; i < 400 && !seen_done; i++) begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus.fl_push_ready = 1'b1;
            end else if (!stall_done && c.stall_len > 0 && bus.fl_push &&
                         int'(bus.fl_push_reg) == c.stall_reg) begin
                bus.fl_push_ready = 1'b0;
                stall_left = c.stall_len;
                stall_done = 1'b1;
            end
            if (bus.recovery_done) seen_done = 1'b1;
        end
        if (!seen_done) begin
            chk("recovery_done_timeout", 0, 1);
            return;
        end
        chk("stall_in_done", 32'(bus.commit_stall), 1);
        @(posedge clk); #1;
        chk("stall_released", 32'(bus.commit_stall), 0);
        chk("idle_after_done", 32'(bus.busy), 0);
        // DONE is the 74th cycle counting SETTLE as the first (73 edges later), plus any stall.
        chk("done_latency", done_cyc - settle_cyc, c.exp_done_off);
        chk("push_count", push_cnt, c.exp_pushes);
        chk("rat_write_count", rat_cnt, ARCH_REGS);
        chk("done_pulses", done_cnt, 1);
        chk("clear_pulses", clear_cnt, 1);
        chk("rat_queue_drained", exp_rat.size(), 0);
        chk("push_queue_drained", exp_push.size(), 0);
    endtask

    initial begin
        case_t ident;
        cases[0] = '{-1, 0, -1, 0, 0, 0, 32, 73};   // identity map
        cases[1] = '{ 5, 40, 9, 50, 0, 0, 32, 73};  // two remapped regs
        cases[2] = '{-1, 0, -1, 0, 33, 3, 32, 76};  // ready low 3 cycles on p33
        cases[3] = '{ 3, 7, -1, 0, 0, 0, 33, 73};   // x3 duplicates x7's p7
        ident = cases[0];

        rst = 1'b1;
        bus.flush_req = 1'b0;
        bus.fl_push_ready = 1'b1;
        for (int a = 0; a < ARCH_REGS; a++) bus.rrf_map[a] = PW'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_commit_stall", 32'(bus.commit_stall), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rat_we", 32'(bus.rat_we), 0);
        chk("rst_fl_clear", 32'(bus.fl_clear), 0);
        chk("rst_fl_push", 32'(bus.fl_push), 0);
        chk("rst_done", 32'(bus.recovery_done), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        foreach (cases[i]) run_case(cases[i]);

        // Requests during COPY and SCAN collapse into exactly one rerun.
        begin
            bit f1, f2, finished;
            int dones_seen;
            reset_stats();
            @(posedge clk); #1;
            build_exp(ident);
            build_exp(ident);
            pulse_flush_from_idle();
            f1 = 1'b0; f2 = 1'b0; finished = 1'b0; dones_seen = 0;
            for (int i = 0; i < 400 && !finished; i++) begin
                @(posedge clk); #1;
                bus.flush_req = 1'b0;
                chk("stall_between_runs", 32'(bus.commit_stall), 1);
                if (dones_seen == 1) begin
                    chk("rerun_settle_next", 32'(bus.fl_clear), 1);
                    dones_seen = 2;
                end
                if (bus.rat_we[0] && !f1) begin
                    bus.flush_req = 1'b1;
                    f1 = 1'b1;
                end else if (bus.fl_push && f1 && !f2) begin
                    bus.flush_req = 1'b1;
                    f2 = 1'b1;
                end
                if (bus.recovery_done) begin
                    if (dones_seen == 0) dones_seen = 1;
                    else finished = 1'b1;
                end
            end
            if (!finished) chk("rerun_timeout", 0, 1);
            bus.flush_req = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
                chk("no_second_rerun", 32'(bus.busy), 0);
            end
            chk("rerun_done_pulses", done_cnt, 2);
            chk("rerun_clear_pulses", clear_cnt, 2);
            chk("rerun_push_count", push_cnt, 64);
            chk("rerun_queues_drained", exp_rat.size() + exp_push.size(), 0);
        end

        // Synchronous reset in mid-SCAN aborts silently; a fresh request then completes.
        begin
            bit hit;
            reset_stats();
            @(posedge clk); #1;
            build_exp(ident);
            pulse_flush_from_idle();
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(posedge clk); #1;
                if (bus.fl_push && int'(bus.fl_push_reg) >= 40) hit = 1'b1;
            end
            if (!hit) chk("scan_reach_timeout", 0, 1);
            rst = 1'b1;
            @(posedge clk); #1;
            mon_en = 1'b0;
            chk("mid_rst_commit_stall", 32'(bus.commit_stall), 0);
            chk("mid_rst_busy", 32'(bus.busy), 0);
            chk("mid_rst_rat_we", 32'(bus.rat_we), 0);
            chk("mid_rst_fl_clear", 32'(bus.fl_clear), 0);
            chk("mid_rst_fl_push", 32'(bus.fl_push), 0);
            chk("mid_rst_push_reg", 32'(bus.fl_push_reg), 0);
            chk("mid_rst_done", 32'(bus.recovery_done), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            exp_rat.delete();
            exp_push.delete();
            prev_held = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                chk("post_rst_no_done", 32'(bus.recovery_done), 0);
                chk("post_rst_idle", 32'(bus.busy), 0);
            end
            mon_en = 1'b1;
            run_case(ident);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
